// File: rtl/timer_run_controller_if.sv
// rtl/timer_run_controller_if.sv - keypad, button, timebase and display signals of the microwave run timer
interface timer_run_controller_if;
    logic [3:0] D;
    logic       loadn;
    logic       pgt_1Hz;
    logic       startn;
    logic       stopn;
    logic       clearn;
    logic       door_closed;
    logic [3:0] min_tens;
    logic [3:0] min_ones;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic       mag_on;
    logic       done;
    logic [2:0] state;

    modport master (
        output D, loadn, pgt_1Hz, startn, stopn, clearn, door_closed,
        input  min_tens, min_ones, sec_tens, sec_ones, mag_on, done, state
    );

    modport slave (
        input  D, loadn, pgt_1Hz, startn, stopn, clearn, door_closed,
        output min_tens, min_ones, sec_tens, sec_ones, mag_on, done, state
    );
endinterface

// File: rtl/timer_run_controller.sv
// rtl/timer_run_controller.sv - MM:SS BCD entry/countdown FSM driving the magnetron enable
// Optional door interlock is enabled by defining DOOR_INTERLOCK_EN.
module timer_run_controller (
    input  logic                   clk,
    input  logic                   resetn,
    timer_run_controller_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'b000,
        S_SET   = 3'b001,
        S_RUN   = 3'b010,
        S_PAUSE = 3'b011,
        S_DONE  = 3'b100
    } state_t;

    state_t     state_q;
    logic [3:0] mt_q, mo_q, st_q, so_q;
    logic [1:0] done_cnt_q;
    logic       mag_on_q, done_q;
    logic       load_prev_q, start_prev_q, stop_prev_q, clear_prev_q, tick_prev_q;

    logic raw_clear, raw_stop, raw_start, raw_load, raw_tick;
    logic ev_stop, ev_start, ev_load, ev_tick;
    logic start_ok, door_trip;
    logic digits_nonzero, d_valid, dec_zero;
    logic [3:0] mt_d, mo_d, st_d, so_d;

    assign raw_clear = clear_prev_q & ~bus.clearn;
    assign raw_stop  = stop_prev_q  & ~bus.stopn;
    assign raw_start = start_prev_q & ~bus.startn;
    assign raw_load  = load_prev_q  & ~bus.loadn;
    assign raw_tick  = ~tick_prev_q & bus.pgt_1Hz;

`ifdef DOOR_INTERLOCK_EN
    assign start_ok  = bus.door_closed;
    assign door_trip = ~bus.door_closed;
`else
    // Door switch has no influence in this build; start is always allowed.
    assign start_ok  = 1'b1 | bus.door_closed;
    assign door_trip = 1'b0;
`endif

    // Only the highest-priority event of a cycle survives; clear is handled directly.
    always_comb begin
        ev_stop  = 1'b0;
        ev_start = 1'b0;
        ev_load  = 1'b0;
        ev_tick  = 1'b0;
        if (!raw_clear) begin
            if (raw_stop)       ev_stop  = 1'b1;
            else if (raw_start) ev_start = 1'b1;
            else if (raw_load)  ev_load  = 1'b1;
            else if (raw_tick)  ev_tick  = 1'b1;
        end
    end

    // One-second BCD decrement; seconds above 59 simply count down in place.
    always_comb begin
        mt_d = mt_q;
        mo_d = mo_q;
        st_d = st_q;
        so_d = so_q;
        if (so_q != 4'd0) begin
            so_d = so_q - 4'd1;
        end else begin
            so_d = 4'd9;
            if (st_q != 4'd0) begin
                st_d = st_q - 4'd1;
            end else begin
                st_d = 4'd5;
                if (mo_q != 4'd0) begin
                    mo_d = mo_q - 4'd1;
                end else begin
                    mo_d = 4'd9;
                    mt_d = mt_q - 4'd1;
                end
            end
        end
    end

    assign dec_zero       = ({mt_d, mo_d, st_d, so_d} == 16'h0000);
    assign digits_nonzero = |{mt_q, mo_q, st_q, so_q};
    assign d_valid        = (bus.D <= 4'd9);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            mt_q         <= 4'd0;
            mo_q         <= 4'd0;
            st_q         <= 4'd0;
            so_q         <= 4'd0;
            done_cnt_q   <= 2'd0;
            mag_on_q     <= 1'b0;
            done_q       <= 1'b0;
            load_prev_q  <= 1'b1;
            start_prev_q <= 1'b1;
            stop_prev_q  <= 1'b1;
            clear_prev_q <= 1'b1;
            tick_prev_q  <= 1'b1;
        end else begin
            load_prev_q  <= bus.loadn;
            start_prev_q <= bus.startn;
            stop_prev_q  <= bus.stopn;
            clear_prev_q <= bus.clearn;
            tick_prev_q  <= bus.pgt_1Hz;

            if (raw_clear) begin
                state_q    <= S_IDLE;
                mt_q       <= 4'd0;
                mo_q       <= 4'd0;
                st_q       <= 4'd0;
                so_q       <= 4'd0;
                done_cnt_q <= 2'd0;
                mag_on_q   <= 1'b0;
                done_q     <= 1'b0;
            end else if (door_trip && state_q == S_RUN) begin
                state_q  <= S_PAUSE;
                mag_on_q <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE, S_SET: begin
                        if (ev_load && d_valid) begin
                            mt_q    <= mo_q;
                            mo_q    <= st_q;
                            st_q    <= so_q;
                            so_q    <= bus.D;
                            state_q <= S_SET;
                        end else if (state_q == S_SET && ev_start && start_ok && digits_nonzero) begin
                            state_q  <= S_RUN;
                            mag_on_q <= 1'b1;
                        end
                    end
                    S_RUN: begin
                        if (ev_stop) begin
                            state_q  <= S_PAUSE;
                            mag_on_q <= 1'b0;
                        end else if (ev_tick) begin
                            mt_q <= mt_d;
                            mo_q <= mo_d;
                            st_q <= st_d;
                            so_q <= so_d;
                            if (dec_zero) begin
                                state_q    <= S_DONE;
                                mag_on_q   <= 1'b0;
                                done_q     <= 1'b1;
                                done_cnt_q <= 2'd0;
                            end
                        end
                    end
                    S_PAUSE: begin
                        if (ev_start && start_ok) begin
                            state_q  <= S_RUN;
                            mag_on_q <= 1'b1;
                        end
                    end
                    S_DONE: begin
                        if (ev_tick) begin
                            if (done_cnt_q == 2'd2) begin
                                state_q    <= S_IDLE;
                                done_q     <= 1'b0;
                                done_cnt_q <= 2'd0;
                                mt_q       <= 4'd0;
                                mo_q       <= 4'd0;
                                st_q       <= 4'd0;
                                so_q       <= 4'd0;
                            end else begin
                                done_cnt_q <= done_cnt_q + 2'd1;
                            end
                        end
                    end
                    default: begin
                        state_q  <= S_IDLE;
                        mag_on_q <= 1'b0;
                        done_q   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.min_tens = mt_q;
    assign bus.min_ones = mo_q;
    assign bus.sec_tens = st_q;
    assign bus.sec_ones = so_q;
    assign bus.mag_on   = mag_on_q;
    assign bus.done     = done_q;
    assign bus.state    = state_q;
endmodule

// File: tb/tb_timer_run_controller.sv
// tb/tb_timer_run_controller.sv - directed and randomized check of the run timer against a seconds-level model
module tb_timer_run_controller;
    localparam int ST_IDLE = 0, ST_SET = 1, ST_RUN = 2, ST_PAUSE = 3, ST_DONE = 4;

    logic clk = 1'b0;
    logic resetn;
    timer_run_controller_if bus();

    timer_run_controller dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    bit cmp_en = 1'b0;

    // Model: minutes and seconds kept as plain integers (seconds may exceed 59 after entry).
    int m_state, m_min, m_sec, m_cnt;
    bit p_ld, p_st, p_sp, p_cl, p_tk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] model_digits();
        return {4'(m_min / 10), 4'(m_min % 10), 4'(m_sec / 10), 4'(m_sec % 10)};
    endfunction

    function automatic logic [15:0] dut_digits();
        return {bus.min_tens, bus.min_ones, bus.sec_tens, bus.sec_ones};
    endfunction

    task automatic model_reset();
        m_state = ST_IDLE; m_min = 0; m_sec = 0; m_cnt = 0;
        p_ld = 1; p_st = 1; p_sp = 1; p_cl = 1; p_tk = 1;
    endtask

    task automatic model_step();
        bit e_ld, e_st, e_sp, e_cl, e_tk, ok;
        if (!resetn) begin
            model_reset();
            return;
        end
        e_cl = p_cl && !bus.clearn;
        e_sp = p_sp && !bus.stopn;
        e_st = p_st && !bus.startn;
        e_ld = p_ld && !bus.loadn;
        e_tk = !p_tk && bus.pgt_1Hz;
        p_cl = bus.clearn; p_sp = bus.stopn; p_st = bus.startn; p_ld = bus.loadn; p_tk = bus.pgt_1Hz;
        if (e_cl) begin
            m_state = ST_IDLE; m_min = 0; m_sec = 0; m_cnt = 0;
            return;
        end
`ifdef DOOR_INTERLOCK_EN
        if (m_state == ST_RUN && !bus.door_closed) begin
            m_state = ST_PAUSE;
            return;
        end
        ok = bus.door_closed;
`else
        ok = 1'b1;
`endif
        if (e_sp) begin e_st = 0; e_ld = 0; e_tk = 0; end
        else if (e_st) begin e_ld = 0; e_tk = 0; end
        else if (e_ld) e_tk = 0;
        case (m_state)
            ST_IDLE, ST_SET: begin
                if (e_ld && bus.D <= 9) begin
                    m_min = (m_min % 10) * 10 + m_sec / 10;
                    m_sec = (m_sec % 10) * 10 + int'(bus.D);
                    m_state = ST_SET;
                end else if (m_state == ST_SET && e_st && ok && (m_min + m_sec) != 0) begin
                    m_state = ST_RUN;
                end
            end
            ST_RUN: begin
                if (e_sp) m_state = ST_PAUSE;
                else if (e_tk) begin
                    if (m_sec > 0) m_sec--;
                    else begin m_sec = 59; m_min--; end
                    if (m_min == 0 && m_sec == 0) begin m_state = ST_DONE; m_cnt = 0; end
                end
            end
            ST_PAUSE: if (e_st && ok) m_state = ST_RUN;
            ST_DONE: if (e_tk) begin
                if (m_cnt == 2) begin m_state = ST_IDLE; m_cnt = 0; m_min = 0; m_sec = 0; end
                else m_cnt++;
            end
            default: m_state = ST_IDLE;
        endcase
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cmp_state", 16'(bus.state), 16'(m_state));
            chk("cmp_digits", dut_digits(), model_digits());
            chk("cmp_mag_on", 16'(bus.mag_on), 16'(m_state == ST_RUN));
            chk("cmp_done", 16'(bus.done), 16'(m_state == ST_DONE));
        end
    end

    task automatic cyc();
        @(posedge clk);
        model_step();
        #2;
    endtask

    task automatic press(input bit ld, input bit st, input bit sp, input bit cl, input logic [3:0] d);
        bus.D = d;
        bus.loadn = ~ld; bus.startn = ~st; bus.stopn = ~sp; bus.clearn = ~cl;
        cyc();
        bus.loadn = 1; bus.startn = 1; bus.stopn = 1; bus.clearn = 1;
        cyc();
    endtask

    task automatic key(input logic [3:0] d);
        press(1, 0, 0, 0, d);
    endtask

    task automatic tick();
        bus.pgt_1Hz = 1; cyc();
        bus.pgt_1Hz = 0; cyc();
    endtask

    task automatic lit(input string name, input logic [15:0] digits, input int st, input bit mag, input bit dn);
        chk({name, "_digits"}, dut_digits(), digits);
        chk({name, "_state"}, 16'(bus.state), 16'(st));
        chk({name, "_mag_on"}, 16'(bus.mag_on), 16'(mag));
        chk({name, "_done"}, 16'(bus.done), 16'(dn));
    endtask

    initial begin
        resetn = 0;
        bus.D = 0; bus.loadn = 1; bus.startn = 1; bus.stopn = 1; bus.clearn = 1;
        bus.pgt_1Hz = 0; bus.door_closed = 1;
        model_reset();
        cmp_en = 1;
        cyc(); cyc();
        lit("reset", 16'h0000, ST_IDLE, 0, 0);
        resetn = 1;
        cyc();
        lit("post_reset", 16'h0000, ST_IDLE, 0, 0);

        // 1:30 full countdown and DONE timeout
        key(1); key(3); key(0);
        lit("entry_130", 16'h0130, ST_SET, 0, 0);
        press(0, 1, 0, 0, 0);
        lit("start_130", 16'h0130, ST_RUN, 1, 0);
        tick();
        lit("tick_129", 16'h0129, ST_RUN, 1, 0);
        for (int i = 0; i < 89; i++) tick();
        lit("reach_done", 16'h0000, ST_DONE, 0, 1);
        tick(); tick();
        lit("done_2ticks", 16'h0000, ST_DONE, 0, 1);
        tick();
        lit("done_exit", 16'h0000, ST_IDLE, 0, 0);

        // borrow across minutes and unnormalized seconds
        key(1); key(0); key(0); key(0);
        press(0, 1, 0, 0, 0);
        tick();
        lit("borrow_959", 16'h0959, ST_RUN, 1, 0);
        press(0, 0, 0, 1, 0);
        key(9); key(9);
        press(0, 1, 0, 0, 0);
        tick();
        lit("unnorm_98", 16'h0098, ST_RUN, 1, 0);
        press(0, 0, 0, 1, 0);
        lit("clear_run", 16'h0000, ST_IDLE, 0, 0);

        // pause holds digits and ignores ticks
        key(5);
        press(0, 1, 0, 0, 0);
        press(0, 0, 1, 0, 0);
        tick(); tick(); tick();
        lit("pause_hold", 16'h0005, ST_PAUSE, 0, 0);
        press(0, 1, 0, 0, 0);
        tick();
        lit("resume_04", 16'h0004, ST_RUN, 1, 0);

        // coincident events
        press(0, 1, 1, 0, 0);
        lit("stop_start", 16'h0004, ST_PAUSE, 0, 0);
        press(0, 0, 0, 1, 0);
        key(7);
        press(1, 0, 0, 1, 3);
        lit("clear_load", 16'h0000, ST_IDLE, 0, 0);
        key(12);
        lit("bad_digit_idle", 16'h0000, ST_IDLE, 0, 0);
        key(3); key(12);
        lit("bad_digit_set", 16'h0003, ST_SET, 0, 0);
        press(0, 0, 0, 1, 0);

        // door interlock
        key(2); key(0);
        press(0, 1, 0, 0, 0);
        bus.door_closed = 0;
        cyc();
`ifdef DOOR_INTERLOCK_EN
        lit("door_open", 16'h0020, ST_PAUSE, 0, 0);
`else
        lit("door_open", 16'h0020, ST_RUN, 1, 0);
`endif
        press(0, 1, 0, 0, 0);
`ifdef DOOR_INTERLOCK_EN
        lit("door_start", 16'h0020, ST_PAUSE, 0, 0);
`else
        lit("door_start", 16'h0020, ST_RUN, 1, 0);
`endif
        bus.door_closed = 1;
        press(0, 0, 0, 1, 0);

        // asynchronous reset mid-RUN
        key(4); key(2);
        press(0, 1, 0, 0, 0);
        lit("run_42", 16'h0042, ST_RUN, 1, 0);
        resetn = 0;
        bus.pgt_1Hz = 1;
        model_reset();
        #1;
        lit("async_reset", 16'h0000, ST_IDLE, 0, 0);
        cyc(); cyc();
        resetn = 1;
        cyc();
        lit("release", 16'h0000, ST_IDLE, 0, 0);
        bus.pgt_1Hz = 0;
        cyc();

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            bus.loadn       = ($urandom_range(0, 5) != 0);
            bus.D           = 4'($urandom_range(0, 11));
            bus.startn      = ($urandom_range(0, 7) != 0);
            bus.stopn       = ($urandom_range(0, 19) != 0);
            bus.clearn      = ($urandom_range(0, 79) != 0);
            bus.pgt_1Hz     = 1'($urandom_range(0, 1));
            bus.door_closed = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 499) == 0) begin
                resetn = 0;
                model_reset();
                #1;
                chk("rand_async_mag", 16'(bus.mag_on), 16'h0);
                cyc();
                resetn = 1;
            end
            cyc();
        end

        cmp_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/timer_run_controller.md
TIMER_RUN_CONTROLLER -- requirements
Module: timer_run_controller

Interface
REQ-001 SHALL have ports: clk  in  1  system clock; all state updates on rising edge.
REQ-002 SHALL have: resetn  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have: D  in  4  BCD digit from the keypad encoder.
REQ-004 SHALL have: loadn  in  1  active-low digit-valid strobe from the keypad encoder.
REQ-005 SHALL have: pgt_1Hz  in  1  1 Hz timebase; each rising edge is one tick.
REQ-006 SHALL have: startn, stopn, clearn  in  1 each  active-low buttons.
REQ-007 SHALL have: door_closed  in  1  1 = door closed.
REQ-008 SHALL have: min_tens, min_ones, sec_tens, sec_ones  out  4 each  BCD MM:SS display value.
REQ-009 SHALL have: mag_on  out  1  load enable, high only in RUN; done  out  1  high only in DONE; state  out  3  current FSM encoding.

Function
REQ-010 SHALL treat loadn, startn, stopn and clearn as events only on a synchronously detected falling edge (high in the previous cycle, low in this cycle), and pgt_1Hz only on a detected rising edge; each event lasts one clk cycle.
REQ-011 SHALL implement states IDLE=000, SET=001, RUN=010, PAUSE=011, DONE=100; all outputs registered; a transition takes effect on the edge where its event is sampled.
REQ-012 SHALL apply event priority clearn > stopn > startn > loadn > tick when several coincide in one cycle; lower-priority events in that cycle are discarded.
REQ-013 SHALL on clearn from any state go to IDLE with all four digits 0.
REQ-014 SHALL in IDLE or SET, on a loadn event with D <= 9, shift left: min_tens<=min_ones, min_ones<=sec_tens, sec_tens<=sec_ones, sec_ones<=D, and go to SET; D > 9 is ignored; loadn in RUN, PAUSE or DONE is ignored.
REQ-015 SHALL in SET, on startn with a nonzero MM:SS value and start permitted (REQ-025), go to RUN; startn in IDLE, or in SET with 0000, is ignored.
REQ-016 SHALL in RUN, on each tick, decrement MM:SS by one in BCD: sec_ones 0->9 with a borrow from sec_tens; sec_tens 0->5 with a borrow from min_ones; min_ones 0->9 with a borrow from min_tens. Seconds entered above 59 (e.g. 0:99) count down without normalization.
REQ-017 SHALL go to DONE on the same edge on which the decrement produces 0000; mag_on is low from that edge.
REQ-018 SHALL in RUN, on stopn, go to PAUSE with digits held; in PAUSE, startn (if permitted) returns to RUN; ticks in PAUSE are ignored.
REQ-019 SHALL in DONE count three ticks using an internal 2-bit counter, then go to IDLE with digits 0000; clearn exits immediately.
REQ-020 SHALL hold digits unchanged in every state except on the events in REQ-013, REQ-014, REQ-016 and REQ-019.

Reset
REQ-021 SHALL on resetn low immediately force state=IDLE, digits=0000, mag_on=0, done=0 and done counter=0.
REQ-022 SHALL reset the edge-detect registers for active-low inputs to 1 and for pgt_1Hz to 1, so that no event fires in the first cycle after reset.
REQ-023 SHALL, when reset is asserted mid-RUN, deassert mag_on asynchronously, and after release stay in IDLE until new input arrives.

Configuration
REQ-024 SHALL support the macro DOOR_INTERLOCK_EN.
REQ-025 SHALL, with DOOR_INTERLOCK_EN defined, block startn while door_closed=0 and move RUN->PAUSE on the first cycle door_closed=0 is sampled; without the macro, door_closed is present but ignored and start is always permitted.

Verification
REQ-026 SHALL cover: keys 1,3,0 then startn -> digits 01:30, state RUN, mag_on=1; first tick -> 01:29; after 90 ticks -> 00:00, DONE, done=1; after 3 more ticks -> IDLE.
REQ-027 SHALL cover: entry 10:00, start, one tick -> 09:59; entry 0:99, start, one tick -> 00:98.
REQ-028 SHALL cover: RUN at 00:05, stopn -> PAUSE; 3 ticks -> 00:05 held; startn -> RUN; next tick -> 00:04.
REQ-029 SHALL cover: stopn and startn falling in the same cycle during RUN -> PAUSE; clearn together with loadn in SET -> IDLE, 0000; D=12 with loadn -> no change.
REQ-030 SHALL cover, with DOOR_INTERLOCK_EN: door_closed=0 in RUN -> PAUSE with mag_on=0 next edge; startn while open -> stays PAUSE. Without the macro: same stimulus -> stays RUN.
REQ-031 SHALL cover: resetn pulsed low at 00:42 in RUN -> mag_on=0 immediately, 0000, IDLE; no tick or key event in the first cycle after release.
